// File: rtl/mcores_job_scheduler_if.sv
// rtl/mcores_job_scheduler_if.sv - scheduler <-> mining core array bus
//
// Purpose: bundles the per-core range request/grant handshake, the found-hash
// reports and the global stop level shared between the job scheduler and the
// core array.
//
// Signals (direction as seen by the scheduler, modport master):
//   i_core_req          in   CORES_QNT          per-core level: core idle, wants a range
//   o_core_ack          out  CORES_QNT          one-hot 1-cycle grant pulse
//   o_core_nonce        out  NONCE_W            granted range start, valid with o_core_ack
//   i_core_found        in   CORES_QNT          per-core 1-cycle found pulse
//   i_core_found_nonce  in   CORES_QNT*NONCE_W  per-core found nonce, slice c = [c*NONCE_W +: NONCE_W]
//   o_core_stop         out  1                  level: cores must halt
// The core array connects through modport slave.

interface mcores_job_scheduler_if #(
  parameter int CORES_QNT = 4,
  parameter int NONCE_W   = 64
);

  logic [CORES_QNT-1:0]         i_core_req;
  logic [CORES_QNT-1:0]         o_core_ack;
  logic [NONCE_W-1:0]           o_core_nonce;
  logic [CORES_QNT-1:0]         i_core_found;
  logic [CORES_QNT*NONCE_W-1:0] i_core_found_nonce;
  logic                         o_core_stop;

  modport master (
    input  i_core_req,
    output o_core_ack,
    output o_core_nonce,
    input  i_core_found,
    input  i_core_found_nonce,
    output o_core_stop
  );

  modport slave (
    output i_core_req,
    input  o_core_ack,
    input  o_core_nonce,
    output i_core_found,
    output i_core_found_nonce,
    input  o_core_stop
  );

endinterface

// File: rtl/mcores_job_scheduler.sv
// rtl/mcores_job_scheduler.sv - multi-core PoW nonce range dispatcher and winner picker
//
// Purpose: hands out disjoint nonce ranges of 2**RANGE_LOG2 nonces to the mining
// cores in round-robin order, captures the first found hash (lowest core index
// wins on a tie) and then halts every core.
//
// Ports:
//   i_clk          in   1                    system clock, rising edge
//   i_reset        in   1                    synchronous, active-high reset
//   i_start        in   1                    pulse: load i_nonce_base, clear result, begin dispatch
//   i_stop         in   1                    pulse: abort, return to IDLE
//   i_nonce_base   in   NONCE_W              first nonce of the job
//   core_bus       master modport            core request/grant/found bus
//   o_busy         out  1                    high in RUN
//   o_found        out  1                    a winner has been captured
//   o_found_core   out  $clog2(CORES_QNT)+1  index of winning core
//   o_found_nonce  out  NONCE_W              nonce reported by winning core
//   o_ranges_qnt   out  CNT_W                ranges granted this job, saturating
//   o_exhausted    out  1                    nonce space wrapped, no further grants

module mcores_job_scheduler #(
  parameter int CORES_QNT  = 4,
  parameter int NONCE_W    = 64,
  parameter int RANGE_LOG2 = 16,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = $clog2(CORES_QNT) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [NONCE_W-1:0]         i_nonce_base,
  mcores_job_scheduler_if.master     core_bus,
  output logic                       o_busy,
  output logic                       o_found,
  output logic [IDX_W-1:0]           o_found_core,
  output logic [NONCE_W-1:0]         o_found_nonce,
  output logic [CNT_W-1:0]           o_ranges_qnt,
  output logic                       o_exhausted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FOUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [NONCE_W:0] RANGE_STEP = {{NONCE_W{1'b0}}, 1'b1} << RANGE_LOG2;
  localparam logic [IDX_W-1:0] RR_INIT    = IDX_W'(CORES_QNT - 1);

  logic [1:0]           state;
  logic [IDX_W-1:0]     rr;
  logic [NONCE_W-1:0]   next_base;
  logic [CORES_QNT-1:0] ack_q;
  logic [NONCE_W-1:0]   nonce_q;

  logic [CORES_QNT-1:0] eligible;
  logic                 grant_hit;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_found;
  logic [IDX_W-1:0]     win_idx;
  logic [NONCE_W-1:0]   win_nonce;
  logic [NONCE_W:0]     base_sum;
  logic                 job_start;

  assign core_bus.o_core_ack   = ack_q;
  assign core_bus.o_core_nonce = nonce_q;
  assign core_bus.o_core_stop  = (state != ST_RUN);
  assign o_busy                = (state == ST_RUN);

  // A core acked last cycle still shows req high until it sees the ack, so it
  // is masked to avoid granting it a second range back to back.
  assign eligible  = core_bus.i_core_req & ~ack_q;
  assign any_found = |core_bus.i_core_found;
  // The extra top bit is the wrap detector for the nonce space.
  assign base_sum  = {1'b0, next_base} + RANGE_STEP;
  // Start is honoured from every state except RUN; stop in the same cycle wins.
  assign job_start = i_start && !i_stop && (state != ST_RUN);

  // Round-robin search starting one past the last granted core.
  always_comb begin
    int c;
    grant_hit = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int i = 1; i <= CORES_QNT; i++) begin
      c = (int'(rr) + i) % CORES_QNT;
      if (!grant_hit && eligible[c]) begin
        grant_hit = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

  // Descending scan so the lowest-index reporting core is the last write.
  always_comb begin
    win_idx   = '0;
    win_nonce = '0;
    for (int c = CORES_QNT - 1; c >= 0; c--) begin
      if (core_bus.i_core_found[c]) begin
        win_idx   = IDX_W'(c);
        win_nonce = core_bus.i_core_found_nonce[c*NONCE_W +: NONCE_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      rr            <= RR_INIT;
      next_base     <= '0;
      ack_q         <= '0;
      nonce_q       <= '0;
      o_found       <= 1'b0;
      o_found_core  <= '0;
      o_found_nonce <= '0;
      o_ranges_qnt  <= '0;
      o_exhausted   <= 1'b0;
    end else begin
      // Grants are single-cycle pulses; only a RUN grant below re-asserts them.
      ack_q   <= '0;
      nonce_q <= '0;
      if (job_start) begin
        state         <= ST_RUN;
        next_base     <= i_nonce_base;
        o_found       <= 1'b0;
        o_found_core  <= '0;
        o_found_nonce <= '0;
        o_ranges_qnt  <= '0;
        o_exhausted   <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (i_stop) begin
              state <= ST_IDLE;
            end else if (any_found) begin
              state         <= ST_FOUND;
              o_found       <= 1'b1;
              o_found_core  <= win_idx;
              o_found_nonce <= win_nonce;
            end else if (grant_hit) begin
              ack_q     <= CORES_QNT'(1) << grant_idx;
              nonce_q   <= next_base;
              rr        <= grant_idx;
              next_base <= base_sum[NONCE_W-1:0];
              if (o_ranges_qnt != {CNT_W{1'b1}}) begin
                o_ranges_qnt <= o_ranges_qnt + CNT_W'(1);
              end
              if (base_sum[NONCE_W]) begin
                o_exhausted <= 1'b1;
                state       <= ST_DONE;
              end
            end
          end
          ST_FOUND: begin
            if (i_stop) begin
              state <= ST_IDLE;
            end
          end
          ST_DONE: begin
            // Cores still finishing their last range may report a hit here.
            if (i_stop) begin
              state <= ST_IDLE;
            end else if (any_found) begin
              state         <= ST_FOUND;
              o_found       <= 1'b1;
              o_found_core  <= win_idx;
              o_found_nonce <= win_nonce;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcores_job_scheduler.sv
// tb/tb_mcores_job_scheduler.sv - directed self-checking bench for mcores_job_scheduler

module tb_mcores_job_scheduler;

  localparam int CORES_QNT  = 4;
  localparam int NONCE_W    = 64;
  localparam int RANGE_LOG2 = 16;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = $clog2(CORES_QNT) + 1;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic [NONCE_W-1:0] nonce_base;
  logic               busy;
  logic               found;
  logic [IDX_W-1:0]   found_core;
  logic [NONCE_W-1:0] found_nonce;
  logic [CNT_W-1:0]   ranges_qnt;
  logic               exhausted;

  int n_checks;
  int n_errors;

  mcores_job_scheduler_if #(.CORES_QNT(CORES_QNT), .NONCE_W(NONCE_W)) core_bus ();

  mcores_job_scheduler #(
    .CORES_QNT (CORES_QNT),
    .NONCE_W   (NONCE_W),
    .RANGE_LOG2(RANGE_LOG2),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_stop       (stop),
    .i_nonce_base (nonce_base),
    .core_bus     (core_bus),
    .o_busy       (busy),
    .o_found      (found),
    .o_found_core (found_core),
    .o_found_nonce(found_nonce),
    .o_ranges_qnt (ranges_qnt),
    .o_exhausted  (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_found(input logic [3:0] mask, input logic [63:0] n0, input logic [63:0] n1,
                           input logic [63:0] n2, input logic [63:0] n3);
    core_bus.i_core_found = mask;
    core_bus.i_core_found_nonce = {n3, n2, n1, n0};
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    nonce_base = '0;
    core_bus.i_core_req = '0;
    set_found(4'b0000, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    check_eq("rst_ack", core_bus.o_core_ack, 0);
    check_eq("rst_core_stop", core_bus.o_core_stop, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_found", found, 0);
    check_eq("rst_ranges", ranges_qnt, 0);
    check_eq("rst_exhausted", exhausted, 0);
    check_eq("rst_nonce", core_bus.o_core_nonce, 0);
    reset = 1'b0;
    tick();

    // Round-robin dispatch with every core requesting
    nonce_base = 64'h1000;
    core_bus.i_core_req = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_core_stop", core_bus.o_core_stop, 0);
    check_eq("start_no_ack", core_bus.o_core_ack, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("rr_ack", core_bus.o_core_ack, 64'(1) << (k % 4));
      check_eq("rr_nonce", core_bus.o_core_nonce, 64'h1000 + 64'(k) * 64'h10000);
      check_eq("rr_ranges", ranges_qnt, 64'(k + 1));
    end

    // Single requester: masking forces at most every other cycle
    core_bus.i_core_req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        check_eq("mask_ack", core_bus.o_core_ack, 4'b0100);
        check_eq("mask_nonce", core_bus.o_core_nonce, 64'h61000 + 64'(k / 2) * 64'h10000);
      end else begin
        check_eq("mask_gap", core_bus.o_core_ack, 0);
      end
    end
    check_eq("mask_ranges", ranges_qnt, 9);

    // Simultaneous found on cores 1 and 3: lowest index wins, no grant that edge
    core_bus.i_core_req = 4'hF;
    set_found(4'b1010, 0, 64'hAA, 0, 64'hBB);
    tick();
    set_found(4'b0000, 0, 0, 0, 0);
    check_eq("found_no_ack", core_bus.o_core_ack, 0);
    check_eq("found_flag", found, 1);
    check_eq("found_core", found_core, 1);
    check_eq("found_nonce", found_nonce, 64'hAA);
    check_eq("found_core_stop", core_bus.o_core_stop, 1);
    check_eq("found_busy", busy, 0);
    set_found(4'b1000, 0, 0, 0, 64'hBB);
    tick();
    set_found(4'b0000, 0, 0, 0, 0);
    check_eq("late_found_core", found_core, 1);
    check_eq("late_found_nonce", found_nonce, 64'hAA);
    check_eq("late_found_ack", core_bus.o_core_ack, 0);
    check_eq("found_ranges_kept", ranges_qnt, 9);

    // Stop back to IDLE keeps results; start+stop together stays idle
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_found_kept", found, 1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("startstop_busy", busy, 0);
    check_eq("startstop_core_stop", core_bus.o_core_stop, 1);
    check_eq("startstop_found_kept", found, 1);
    tick();
    check_eq("startstop_no_ack", core_bus.o_core_ack, 0);

    // Last range of the nonce space: one grant then exhausted
    nonce_base = 64'hFFFF_FFFF_FFFF_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wrap_start_busy", busy, 1);
    check_eq("wrap_found_clr", found, 0);
    check_eq("wrap_ranges_clr", ranges_qnt, 0);
    tick();
    check_eq("wrap_ack", core_bus.o_core_ack, 4'b1000);
    check_eq("wrap_nonce", core_bus.o_core_nonce, 64'hFFFF_FFFF_FFFF_0000);
    check_eq("wrap_exhausted", exhausted, 1);
    check_eq("wrap_busy", busy, 0);
    check_eq("wrap_ranges", ranges_qnt, 1);
    tick();
    check_eq("wrap_no_ack1", core_bus.o_core_ack, 0);
    tick();
    check_eq("wrap_no_ack2", core_bus.o_core_ack, 0);

    // Found pulse while DONE is still captured
    set_found(4'b0001, 64'h55, 0, 0, 0);
    tick();
    set_found(4'b0000, 0, 0, 0, 0);
    check_eq("done_found", found, 1);
    check_eq("done_found_core", found_core, 0);
    check_eq("done_found_nonce", found_nonce, 64'h55);

    // Restart from FOUND, then stop during RUN
    core_bus.i_core_req = 4'h0;
    nonce_base = 64'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_busy", busy, 1);
    check_eq("restart_exhausted_clr", exhausted, 0);
    check_eq("restart_found_clr", found, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("run_stop_core_stop", core_bus.o_core_stop, 1);
    check_eq("run_stop_busy", busy, 0);

    // Reset during an ack cycle, then core 0 is served first again
    core_bus.i_core_req = 4'hF;
    nonce_base = 64'h2000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("pre_rst_ack0", core_bus.o_core_ack, 4'b0001);
    tick();
    check_eq("pre_rst_ack1", core_bus.o_core_ack, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_ack", core_bus.o_core_ack, 0);
    check_eq("mid_rst_core_stop", core_bus.o_core_stop, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ranges", ranges_qnt, 0);
    check_eq("mid_rst_nonce", core_bus.o_core_nonce, 0);
    nonce_base = 64'h3000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("post_rst_ack", core_bus.o_core_ack, 4'b0001);
    check_eq("post_rst_nonce", core_bus.o_core_nonce, 64'h3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
